// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencer and receive buffer for the UART receiver datapath.
// Watches the synchronised serial line for a start edge, arms the receiver
// with a one-cycle rx_start_o, captures completed frames into a small FIFO
// presented on a valid/ready interface, and keeps saturating error counters
// plus a sticky overrun flag for the host status register.
// Build option: define UART_RX_CTRL_TIMEOUT_EN to include the frame watchdog
// and make timeout_cnt_o live; without it timeout_cnt_o is tied to zero.
module uart_rx_ctrl #(
    parameter int DATA_WD        = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int CNT_WD         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable_i,
    input  logic                        rx_line_i,
    input  logic                        rx_done_i,
    input  logic                        rx_busy_i,
    input  logic                        framing_error_flag_i,
    input  logic                        parity_error_flag_i,
    input  logic [DATA_WD-1:0]          rx_dout_i,
    output logic                        rx_start_o,
    output logic [DATA_WD-1:0]          m_data_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        overrun_o,
    output logic [CNT_WD-1:0]           frame_err_cnt_o,
    output logic [CNT_WD-1:0]           parity_err_cnt_o,
    output logic [CNT_WD-1:0]           timeout_cnt_o,
    input  logic                        clr_status_i
);

    localparam int                  PTR_WD  = $clog2(FIFO_DEPTH);
    localparam int                  FCNT_WD = PTR_WD + 1;
    localparam logic [FCNT_WD-1:0]  DEPTH_C = FCNT_WD'(FIFO_DEPTH);
    localparam logic [CNT_WD-1:0]   CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_ERR,
        S_RECOVER
    } state_t;

    // Synchroniser and edge history
    logic sync1_q, sync2_q, linePrev_q;
    logic lineFall;

    // Sequencer state
    state_t             state_q;
    logic               rxStart_q;
    logic               errFrame_q;
    logic               errParity_q;
    logic [DATA_WD-1:0] capData_q;

    // FIFO
    logic [DATA_WD-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PTR_WD-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_WD-1:0]  rdPtr_q, rdPtr_d;
    logic [FCNT_WD-1:0] fifoCount_q, fifoCount_d;
    logic               push, pop, fifoFull, pushOk, overrunEvt;

    // Status
    logic               overrun_q, overrun_d;
    logic [CNT_WD-1:0]  frameErrCnt_q, frameErrCnt_d;
    logic [CNT_WD-1:0]  parityErrCnt_q, parityErrCnt_d;

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int                 WD_WD   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_WD-1:0]   WD_LAST = WD_WD'(TIMEOUT_CYCLES - 1);
    logic [WD_WD-1:0]  wdCnt_q;
    logic              errTimeout_q;
    logic [CNT_WD-1:0] timeoutCnt_q, timeoutCnt_d;
`endif

    // Two-flop synchroniser plus one history flop; all reset to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            linePrev_q <= 1'b1;
        end else begin
            sync1_q    <= rx_line_i;
            sync2_q    <= sync1_q;
            linePrev_q <= sync2_q;
        end
    end

    assign lineFall = linePrev_q & ~sync2_q;

    // Frame sequencer: arms on a start edge, waits for the receiver, then routes to capture or error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rxStart_q    <= 1'b0;
            errFrame_q   <= 1'b0;
            errParity_q  <= 1'b0;
            capData_q    <= '0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
            wdCnt_q      <= '0;
            errTimeout_q <= 1'b0;
`endif
        end else begin
            rxStart_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                    end else if (lineFall) begin
                        state_q   <= S_START;
                        rxStart_q <= 1'b1;
`ifdef UART_RX_CTRL_TIMEOUT_EN
                        wdCnt_q   <= '0;
`endif
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
`ifdef UART_RX_CTRL_TIMEOUT_EN
                    wdCnt_q <= wdCnt_q + 1'b1;
`endif
                end
                S_WAIT: begin
                    if (framing_error_flag_i || parity_error_flag_i) begin
                        state_q      <= S_ERR;
                        errFrame_q   <= framing_error_flag_i;
                        errParity_q  <= parity_error_flag_i;
`ifdef UART_RX_CTRL_TIMEOUT_EN
                        errTimeout_q <= 1'b0;
`endif
                    end else if (rx_done_i) begin
                        state_q   <= S_CAPTURE;
                        capData_q <= rx_dout_i;
`ifdef UART_RX_CTRL_TIMEOUT_EN
                    end else if (wdCnt_q == WD_LAST) begin
                        state_q      <= S_ERR;
                        errFrame_q   <= 1'b0;
                        errParity_q  <= 1'b0;
                        errTimeout_q <= 1'b1;
                    end else begin
                        wdCnt_q <= wdCnt_q + 1'b1;
`endif
                    end
                end
                S_CAPTURE: begin
                    state_q <= S_RECOVER;
                end
                S_ERR: begin
                    state_q      <= S_RECOVER;
                    errFrame_q   <= 1'b0;
                    errParity_q  <= 1'b0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
                    errTimeout_q <= 1'b0;
`endif
                end
                S_RECOVER: begin
                    if (!rx_busy_i && !rx_done_i && sync2_q) begin
                        state_q <= enable_i ? S_ARM : S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign push       = (state_q == S_CAPTURE);
    assign pop        = m_valid_o & m_ready_i;
    assign fifoFull   = (fifoCount_q == DEPTH_C);
    assign pushOk     = push & (~fifoFull | pop);
    assign overrunEvt = push & fifoFull & ~pop;

    // Next FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        fifoCount_d = fifoCount_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (pushOk && !pop) begin
            fifoCount_d = fifoCount_q + 1'b1;
        end else if (!pushOk && pop) begin
            fifoCount_d = fifoCount_q - 1'b1;
        end
    end

    // FIFO storage and pointers; the head entry drives m_data_o directly from storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_q[i] <= '0;
            end
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (pushOk) begin
                fifoMem_q[wrPtr_q] <= capData_q;
            end
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            fifoCount_q <= fifoCount_d;
        end
    end

    // Sticky overrun and saturating error counts; a clear beats any same-cycle event
    always_comb begin
        overrun_d      = overrun_q | overrunEvt;
        frameErrCnt_d  = frameErrCnt_q;
        parityErrCnt_d = parityErrCnt_q;
        if (state_q == S_ERR) begin
            if (errFrame_q && (frameErrCnt_q != CNT_MAX)) begin
                frameErrCnt_d = frameErrCnt_q + 1'b1;
            end
            if (errParity_q && (parityErrCnt_q != CNT_MAX)) begin
                parityErrCnt_d = parityErrCnt_q + 1'b1;
            end
        end
        if (clr_status_i) begin
            overrun_d      = 1'b0;
            frameErrCnt_d  = '0;
            parityErrCnt_d = '0;
        end
    end

    // Status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q      <= 1'b0;
            frameErrCnt_q  <= '0;
            parityErrCnt_q <= '0;
        end else begin
            overrun_q      <= overrun_d;
            frameErrCnt_q  <= frameErrCnt_d;
            parityErrCnt_q <= parityErrCnt_d;
        end
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    // Timeout count advances in the error cycle that a watchdog expiry produced
    always_comb begin
        timeoutCnt_d = timeoutCnt_q;
        if ((state_q == S_ERR) && errTimeout_q && (timeoutCnt_q != CNT_MAX)) begin
            timeoutCnt_d = timeoutCnt_q + 1'b1;
        end
        if (clr_status_i) begin
            timeoutCnt_d = '0;
        end
    end

    // Timeout count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeoutCnt_q <= '0;
        end else begin
            timeoutCnt_q <= timeoutCnt_d;
        end
    end

    assign timeout_cnt_o = timeoutCnt_q;
`else
    assign timeout_cnt_o = '0;
`endif

    assign rx_start_o       = rxStart_q;
    assign m_data_o         = fifoMem_q[rdPtr_q];
    assign m_valid_o        = (fifoCount_q != '0);
    assign fifo_count_o     = fifoCount_q;
    assign overrun_o        = overrun_q;
    assign frame_err_cnt_o  = frameErrCnt_q;
    assign parity_err_cnt_o = parityErrCnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl.
// A behavioural model (byte queue plus plain integer counters) predicts the
// FIFO contents, status counters and rx_start timing cycle by cycle.
// With UART_RX_CTRL_TIMEOUT_EN defined the watchdog scenario is also run.
module tb_uart_rx_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int TMO   = 100;
    localparam int CMAX  = 255;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable, rxLine, rxDone, rxBusy, feFlag, peFlag, mReady, clrStatus;
    logic [DW-1:0]  rxDout;
    logic           rxStart, mValid, overrun;
    logic [DW-1:0]  mData;
    logic [2:0]     fifoCount;
    logic [CW-1:0]  frameErrCnt, parityErrCnt, timeoutCnt;

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .DATA_WD(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .CNT_WD(CW)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .rx_line_i(rxLine),
        .rx_done_i(rxDone), .rx_busy_i(rxBusy),
        .framing_error_flag_i(feFlag), .parity_error_flag_i(peFlag),
        .rx_dout_i(rxDout), .rx_start_o(rxStart), .m_data_o(mData),
        .m_valid_o(mValid), .m_ready_i(mReady), .fifo_count_o(fifoCount),
        .overrun_o(overrun), .frame_err_cnt_o(frameErrCnt),
        .parity_err_cnt_o(parityErrCnt), .timeout_cnt_o(timeoutCnt),
        .clr_status_i(clrStatus)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model state
    logic [DW-1:0] expQ [$];
    int            expOverrun, expFe, expPe, expTo;
    bit            curPush, curFe, curPe, curTo;
    bit            pendPush, pendFe, pendPe, pendTo;
    logic [DW-1:0] curData, pendData;
    int            startCd = -1;
    int            readyMode = 0;
    bit            randClr = 0;

    // Global time bound so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        expOverrun = 0; expFe = 0; expPe = 0; expTo = 0;
        curPush = 0; curFe = 0; curPe = 0; curTo = 0;
        pendPush = 0; pendFe = 0; pendPe = 0; pendTo = 0;
        startCd = -1;
    endtask

    // Advance one clock: apply the model for the coming edge, then compare at the negedge
    task automatic stepCycle();
        bit doPush, doFe, doPe, doTo, doPop, expStart;
        logic [DW-1:0] doData;
        doPush = pendPush; doFe = pendFe; doPe = pendPe; doTo = pendTo; doData = pendData;
        pendPush = curPush; pendFe = curFe; pendPe = curPe; pendTo = curTo; pendData = curData;
        curPush = 0; curFe = 0; curPe = 0; curTo = 0;
        case (readyMode)
            0:       mReady = 1'b0;
            1:       mReady = 1'b1;
            3:       mReady = doPush;
            default: mReady = 1'($urandom_range(0, 1));
        endcase
        if (randClr) clrStatus = ($urandom_range(0, 15) == 0);
        doPop = mReady && (expQ.size() > 0);
        if (doPop) void'(expQ.pop_front());
        if (doPush) begin
            if (expQ.size() < DEPTH) expQ.push_back(doData);
            else expOverrun = 1;
        end
        if (doFe && expFe < CMAX) expFe++;
        if (doPe && expPe < CMAX) expPe++;
        if (doTo && expTo < CMAX) expTo++;
        if (clrStatus) begin
            expOverrun = 0; expFe = 0; expPe = 0; expTo = 0;
        end
        if (startCd >= 0) startCd--;
        expStart = (startCd == 0);
        @(negedge clk);
        checkOutput("rx_start", rxStart, expStart);
        checkOutput("m_valid", mValid, (expQ.size() > 0));
        checkOutput("fifo_count", fifoCount, expQ.size());
        if (expQ.size() > 0) checkOutput("m_data", mData, expQ[0]);
        checkOutput("overrun", overrun, expOverrun);
        checkOutput("frame_err_cnt", frameErrCnt, expFe);
        checkOutput("parity_err_cnt", parityErrCnt, expPe);
        checkOutput("timeout_cnt", timeoutCnt, expTo);
    endtask

    // Line idle gap, start edge, receiver busy, then a frame-complete pulse with optional error flags
    task automatic applyStimulus(input logic [DW-1:0] data, input bit fe, input bit pe,
                                 input int busyLen, input bit clrAtErr);
        rxLine = 1; rxBusy = 0; rxDone = 0; feFlag = 0; peFlag = 0;
        repeat (6) stepCycle();
        rxLine = 0;
        startCd = 3;
        repeat (3) stepCycle();
        rxBusy = 1;
        for (int i = 0; i < busyLen; i++) begin
            rxLine = 1'($urandom_range(0, 1));
            rxDout = DW'($urandom);
            stepCycle();
        end
        rxDone = 1; rxDout = data; feFlag = fe; peFlag = pe; rxLine = 1;
        if (fe || pe) begin
            curFe = fe; curPe = pe;
        end else begin
            curPush = 1; curData = data;
        end
        stepCycle();
        rxDone = 0; rxBusy = 0; feFlag = 0; peFlag = 0; rxDout = DW'($urandom);
        if (clrAtErr) begin
            clrStatus = 1;
            stepCycle();
            clrStatus = 0;
        end
        stepCycle();
    endtask

    initial begin
        rst = 1; enable = 0; rxLine = 1; rxDone = 0; rxBusy = 0;
        feFlag = 0; peFlag = 0; mReady = 0; clrStatus = 0; rxDout = '0;
        resetModel();
        #1;
        checkOutput("reset rx_start", rxStart, 0);
        checkOutput("reset m_valid", mValid, 0);
        checkOutput("reset m_data", mData, 0);
        checkOutput("reset fifo_count", fifoCount, 0);
        checkOutput("reset overrun", overrun, 0);
        checkOutput("reset frame_err_cnt", frameErrCnt, 0);
        checkOutput("reset parity_err_cnt", parityErrCnt, 0);
        checkOutput("reset timeout_cnt", timeoutCnt, 0);
        @(negedge clk);
        rst = 0;
        stepCycle();

        $display("[TB] start edge ignored while disabled");
        rxLine = 0;
        repeat (6) stepCycle();
        rxLine = 1;
        repeat (3) stepCycle();
        enable = 1;

        $display("[TB] single frame A5");
        readyMode = 0;
        applyStimulus(8'hA5, 0, 0, 4, 0);
        readyMode = 1;
        repeat (3) stepCycle();

        $display("[TB] five frames into a four-entry FIFO");
        readyMode = 0;
        for (int i = 1; i <= 5; i++) applyStimulus(DW'(i), 0, 0, 3, 0);
        readyMode = 1;
        repeat (6) stepCycle();

        $display("[TB] framing error with same-cycle done, then 3C");
        applyStimulus(8'h5E, 1, 0, 2, 0);
        applyStimulus(8'h3C, 0, 0, 2, 0);
        repeat (3) stepCycle();

        $display("[TB] parity errors with clear on the counting cycle");
        applyStimulus(8'h11, 0, 1, 2, 0);
        applyStimulus(8'h12, 0, 1, 2, 1);

        $display("[TB] full FIFO with pop on the capture of 77");
        readyMode = 0;
        applyStimulus(8'h11, 0, 0, 1, 0);
        applyStimulus(8'h22, 0, 0, 1, 0);
        applyStimulus(8'h33, 0, 0, 1, 0);
        applyStimulus(8'h44, 0, 0, 1, 0);
        readyMode = 3;
        applyStimulus(8'h77, 0, 0, 1, 0);
        readyMode = 1;
        repeat (6) stepCycle();

        $display("[TB] enable dropped mid-frame finishes the frame only");
        rxLine = 1;
        repeat (6) stepCycle();
        rxLine = 0; startCd = 3;
        repeat (3) stepCycle();
        rxBusy = 1; enable = 0;
        repeat (3) stepCycle();
        rxDone = 1; rxDout = 8'h5A; rxLine = 1; curPush = 1; curData = 8'h5A;
        stepCycle();
        rxDone = 0; rxBusy = 0;
        repeat (8) stepCycle();
        rxLine = 0;
        repeat (6) stepCycle();
        rxLine = 1;
        repeat (3) stepCycle();
        enable = 1;

        $display("[TB] counter saturation");
        for (int i = 0; i < 260; i++) applyStimulus(DW'(i), 1, 1, 1, 0);
        repeat (2) stepCycle();

        $display("[TB] asynchronous reset mid-frame");
        readyMode = 0;
        applyStimulus(8'h99, 0, 0, 2, 0);
        rxLine = 1;
        repeat (6) stepCycle();
        rxLine = 0; startCd = 3;
        repeat (3) stepCycle();
        rxBusy = 1;
        repeat (2) stepCycle();
        rst = 1;
        #1;
        checkOutput("midreset m_valid", mValid, 0);
        checkOutput("midreset fifo_count", fifoCount, 0);
        checkOutput("midreset frame_err_cnt", frameErrCnt, 0);
        checkOutput("midreset parity_err_cnt", parityErrCnt, 0);
        resetModel();
        rxBusy = 0; rxLine = 1;
        stepCycle();
        rst = 0;
        readyMode = 1;
        applyStimulus(8'hC3, 0, 0, 3, 0);

`ifdef UART_RX_CTRL_TIMEOUT_EN
        $display("[TB] watchdog expiry with no frame-complete");
        rxLine = 1;
        repeat (6) stepCycle();
        rxLine = 0; startCd = 3;
        repeat (3) stepCycle();
        rxBusy = 1;
        for (int k = 1; k <= TMO + 1; k++) begin
            if (k == TMO) curTo = 1;
            stepCycle();
        end
        rxBusy = 0; rxLine = 1;
        repeat (3) stepCycle();
        applyStimulus(8'h6B, 0, 0, 2, 0);
`endif

        $display("[TB] randomized frames");
        readyMode = 2; randClr = 1;
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            applyStimulus(DW'($urandom), (r == 0 || r == 2), (r == 1 || r == 2),
                          $urandom_range(1, 12), 0);
        end
        randClr = 0; clrStatus = 0;
        readyMode = 1;
        repeat (8) stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
